// File: rtl/imem_fetch_bridge.sv
// Fetch-side bridge: core PC -> pipelined req/gnt/rvalid bus, registered {pc, instr} back to fetch.
// Optional bus error reporting under IMEM_FETCH_BRIDGE_ERR_EN.
//  state  | meaning
//  S_IDLE | no address phase outstanding
//  S_REQ  | bus_req_o held with a fixed address until bus_gnt_i
module imem_fetch_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] core_req_pc_i,
  output logic [31:0] core_rsp_pc_o,
  output logic [31:0] core_rsp_instr_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
`ifdef IMEM_FETCH_BRIDGE_ERR_EN
  input  logic        bus_err_i,
  output logic        err_o,
  output logic [31:0] err_pc_o,
`endif
  output logic        busy_o
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [2:0] CNT_MAX  = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] PTR_LAST = 2'(MAX_OUTSTANDING - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_addr, r_last_pc, r_rsp_pc, r_rsp_instr;
  logic        r_last_valid, r_pend_drop;
  logic [29:0] r_fifo_pc [4];
  logic [3:0]  r_fifo_drop;
  logic [1:0]  r_rd_ptr, r_wr_ptr;
  logic [2:0]  r_count;

  logic        w_issue, w_push, w_pop, w_redirect, w_stale_req, w_push_drop, w_deliver;
  logic [31:0] w_head_pc, w_rsp_data;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == PTR_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count < CNT_MAX) && (!r_last_valid || (core_req_pc_i != r_last_pc))) begin
          w_issue     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt_i) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_redirect  = r_last_valid && (core_req_pc_i != r_last_pc);
  assign w_stale_req = core_req_pc_i[31:2] != r_addr[31:2];
  assign w_push_drop = r_pend_drop | w_stale_req;
  assign w_pop       = bus_rvalid_i && (r_count != 3'd0);
  assign w_head_pc   = {r_fifo_pc[r_rd_ptr], 2'b00};
  // A head popped in a redirect cycle belongs to the abandoned stream as well
  assign w_deliver   = w_pop && !r_fifo_drop[r_rd_ptr] && !w_redirect;

`ifdef IMEM_FETCH_BRIDGE_ERR_EN
  logic        r_err;
  logic [31:0] r_err_pc;

  assign w_rsp_data = bus_err_i ? 32'h0000_0000 : bus_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err    <= 1'b0;
      r_err_pc <= 32'h0;
    end else if (w_deliver && bus_err_i) begin
      r_err    <= 1'b1;
      r_err_pc <= w_head_pc;
    end
  end

  assign err_o    = r_err;
  assign err_pc_o = r_err_pc;
`else
  assign w_rsp_data = bus_rdata_i;
`endif

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_pc[r_wr_ptr] <= r_addr[31:2];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0;
      r_last_pc    <= 32'h0;
      r_last_valid <= 1'b0;
      r_pend_drop  <= 1'b0;
      r_fifo_drop  <= 4'h0;
      r_rd_ptr     <= 2'd0;
      r_wr_ptr     <= 2'd0;
      r_count      <= 3'd0;
      r_rsp_pc     <= 32'hFFFF_FFFF;
      r_rsp_instr  <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_addr      <= {core_req_pc_i[31:2], 2'b00};
        r_pend_drop <= 1'b0;
      end else if ((r_state == S_REQ) && w_stale_req) begin
        r_pend_drop <= 1'b1;
      end
      if (w_redirect) r_fifo_drop <= 4'hF;
      if (w_push) begin
        r_fifo_drop[r_wr_ptr] <= w_push_drop;
        r_wr_ptr              <= ptr_inc(r_wr_ptr);
        r_last_pc             <= r_addr;
        r_last_valid          <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      if (w_deliver) begin
        r_rsp_pc    <= w_head_pc;
        r_rsp_instr <= w_rsp_data;
      end
    end
  end

  assign bus_req_o        = (r_state == S_REQ);
  assign bus_addr_o       = r_addr;
  assign core_rsp_pc_o    = r_rsp_pc;
  assign core_rsp_instr_o = r_rsp_instr;
  assign busy_o           = (r_count != 3'd0) || bus_req_o;

endmodule

// File: doc/imem_fetch_bridge.md
Name: imem_fetch_bridge

Overview:
- Sits directly upstream of the core's fetch stage, between the core instruction-memory port and a pipelined instruction bus with req/gnt/rvalid handshake and variable latency.
- Turns the core's level-held request PC into bus transactions and tracks in-flight transactions in a PC FIFO.
- Discards responses made stale by a core redirect, and presents a registered {pc, instr} pair. The core's fetch stage consumes the pair when the pc matches its own.

Parameters:
- MAX_OUTSTANDING, 2, depth of in-flight FIFO; legal 1..4.
- NOP_INSTR, 32'h0000_0013, instruction driven while no valid response is held.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- core_req_pc_i  in  32  PC requested by the core; held while stalled
- core_rsp_pc_o  out  32  PC of the delivered instruction
- core_rsp_instr_o  out  32  delivered instruction word
- bus_req_o  out  1  bus request
- bus_addr_o  out  32  bus address; word aligned
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  response data valid
- bus_rdata_i  in  32  response data
- busy_o  out  1  FIFO non-empty or request pending

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - core_rsp_pc_o = 32'hFFFF_FFFF (unaligned, never matches).
  - core_rsp_instr_o = NOP_INSTR.
  - bus_req_o = 0, bus_addr_o = 0, busy_o = 0.
  - FIFO empty; last_issued_valid = 0.
- Issue condition:
  - A new request starts when no request is pending, the FIFO is not full (count < MAX_OUTSTANDING), and (!last_issued_valid || core_req_pc_i != last_issued_pc).
  - bus_req_o and bus_addr_o are registered: a request decided in cycle N is visible in cycle N+1.
  - bus_addr_o = {core_req_pc_i[31:2], 2'b00}.
- Pending request:
  - bus_req_o and bus_addr_o stay stable until bus_gnt_i. The address is never changed or withdrawn, even if core_req_pc_i changes.
  - On gnt: push {addr, drop=0} into the FIFO, deassert bus_req_o, and record last_issued_pc = addr, last_issued_valid = 1.
- Redirect:
  - Redirect = core_req_pc_i != last_issued_pc while last_issued_valid.
  - In that cycle, every FIFO entry is marked drop = 1.
  - A pending ungranted request for the old PC is pushed with drop = 1 when granted.
  - The new PC is issued on the following eligible cycle.
- Response path:
  - bus_rvalid_i pops the FIFO head.
  - If the head has drop = 0, core_rsp_pc_o = head.pc and core_rsp_instr_o = bus_rdata_i at the next edge (1-cycle latency).
  - If the head has drop = 1, the data is discarded and the outputs keep their previous value.
- Hold: the response registers hold their value indefinitely until the next non-dropped response.
- Simultaneous gnt and rvalid: push and pop in the same cycle; count unchanged. A full FIFO with a pop in the same cycle still does not issue that cycle; issue eligibility uses the registered count.
- Ordering: responses return in grant order. bus_rvalid_i is never asserted in the same cycle as the gnt of that transaction.
- rvalid with FIFO empty: ignored, no state change. This is tolerated after a mid-operation reset.
- Reset mid-operation: all state returns to reset values in one cycle. Late bus responses are ignored via the empty-FIFO rule.
- busy_o = (count != 0) || bus_req_o.

Optional Feature:
- Macro: IMEM_FETCH_BRIDGE_ERR_EN.
- When defined:
  - Adds port bus_err_i (in, 1), sampled with bus_rvalid_i.
  - Adds ports err_o (out, 1, sticky) and err_pc_o (out, 32).
  - A non-dropped response with err delivers instr 32'h0000_0000 (illegal), sets err_o, and captures err_pc_o = head.pc.
  - Dropped errored responses are ignored.
  - err_o and err_pc_o clear only on reset; reset values are 0.
- When not defined: the three ports are absent and bus errors are not observed.

Test Plan:
- Reset with no bus activity: core_req_pc_i = 0x0 → after reset bus_req_o = 0 for 1 cycle, then bus_req_o = 1, bus_addr_o = 0x0. After gnt plus rvalid with rdata = 0x00500093, core_rsp_pc_o = 0x0 and core_rsp_instr_o = 0x00500093 one cycle after rvalid.
- Sequential stream with zero-wait gnt and rvalid 1 cycle after gnt: PCs 0x0, 0x4, 0x8 → each delivered with its own pc. The core stream never sees a mismatched pc/instr pair.
- Redirect while the response is in flight:
  - Issue 0x10 (granted); the core switches to 0x40 before rvalid.
  - The 0x10 data is discarded and core_rsp_pc_o stays at its prior value.
  - 0x40 is issued and delivered.
- Redirect while the request is ungranted: gnt withheld 3 cycles for 0x20, then the core switches to 0x80 → bus_addr_o stays 0x20 until gnt. The 0x20 response is dropped; 0x80 is issued next and delivered.
- Full FIFO with MAX_OUTSTANDING = 2: two dropped transactions in flight, rvalid withheld → no third bus_req_o until one rvalid arrives. A same-cycle gnt plus rvalid keeps the count at 2.
- With IMEM_FETCH_BRIDGE_ERR_EN: bus_err_i on the response for 0x100 → core_rsp_instr_o = 0x0, err_o = 1, err_pc_o = 0x100. err_o stays 1 after later good responses and clears only on rst_i.
